// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding and the
// chunk-count derivation used to size the datapath sequencing.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int dataWidth, input int chunkWidth);
    return dataWidth / chunkWidth;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple sum of one operand chunk plus carry-in.
module chunk_adder #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] x,
  input  logic [CHUNK_WIDTH-1:0] y,
  input  logic                   ci,
  output logic [CHUNK_WIDTH-1:0] s,
  output logic                   co
);

  logic [CHUNK_WIDTH:0] w_sum;

  assign w_sum   = {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, ci};
  assign {co, s} = w_sum;

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor that sums CHUNK_WIDTH bits per clock, LSB chunk
// first, and pulses done once the full-width result, carry and overflow are ready.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int NCHUNK = calc_nchunk(DATA_WIDTH, CHUNK_WIDTH);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [IDXW-1:0]         r_idx;
  logic                    r_carry;
  logic                    r_aMsb;
  logic                    r_bMsb;
  logic                    r_cout;
  logic                    r_ovf;

  logic [CHUNK_WIDTH-1:0]            w_s;
  logic                              w_co;
  logic [DATA_WIDTH+CHUNK_WIDTH-1:0] w_cat;

  chunk_adder #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
    .x  (r_a[CHUNK_WIDTH-1:0]),
    .y  (r_b[CHUNK_WIDTH-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Operands shift down each cycle and each new chunk enters the result from
  // the top, so after NCHUNK cycles chunk 0 has landed in the low bits.
  assign w_cat = {w_s, r_result};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_aMsb  <= a[DATA_WIDTH-1];
            r_bMsb  <= sub ? ~b[DATA_WIDTH-1] : b[DATA_WIDTH-1];
            r_idx   <= '0;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_result <= w_cat[DATA_WIDTH+CHUNK_WIDTH-1:CHUNK_WIDTH];
          r_carry  <= w_co;
          r_a      <= r_a >> CHUNK_WIDTH;
          r_b      <= r_b >> CHUNK_WIDTH;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_cout  <= w_co;
            r_ovf   <= (r_aMsb == r_bMsb) && (w_s[CHUNK_WIDTH-1] != r_aMsb);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_BUSY);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: expectations are queued at issue time
// and compared when the done pulse appears.
module tb_chunked_adder;

  localparam int DW  = 64;
  localparam int CW  = 8;
  localparam int NCH = DW / CW;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          co;
    logic          ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          cout;
  logic          ovf;

  exp_t sbq[$];
  int   passCnt  = 0;
  int   checkCnt = 0;

  always #5 clk = ~clk;

  chunked_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk    (clk),
    .rst_n  (rstN),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  // Reference: full-width arithmetic, independent of the chunked datapath
  function automatic exp_t model(input logic [DW-1:0] aIn, input logic [DW-1:0] bIn,
                                 input logic cinIn, input logic subIn);
    logic [DW-1:0] bEff;
    logic [DW:0]   sum;
    exp_t          e;
    bEff = subIn ? ~bIn : bIn;
    sum  = {1'b0, aIn} + {1'b0, bEff} + (DW+1)'(subIn ? 1'b1 : cinIn);
    e.res = sum[DW-1:0];
    e.co  = sum[DW];
    e.ov  = (aIn[DW-1] == bEff[DW-1]) && (sum[DW-1] != aIn[DW-1]);
    return e;
  endfunction

  task automatic issue(input logic [DW-1:0] aIn, input logic [DW-1:0] bIn,
                       input logic cinIn, input logic subIn);
    a = aIn; b = bIn; cin = cinIn; sub = subIn; start = 1'b1;
    sbq.push_back(model(aIn, bIn, cinIn, subIn));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 40) begin
      if (busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int lat, bc;
    #1 rstN = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkCnt++;
    if ({busy, done, result, cout, ovf} !== '0) $display("[TB] FAIL reset_init got busy=%b done=%b result=%h cout=%b ovf=%b, want all zero", busy, done, result, cout, ovf);
    else passCnt++;
    rstN = 1'b1;
    issue({DW{1'b1}}, '0, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    #2 rstN = 1'b0;
    #1;
    checkCnt++;
    if ({busy, done, result, cout, ovf} !== '0) $display("[TB] FAIL reset_async got busy=%b done=%b result=%h cout=%b ovf=%b, want all zero", busy, done, result, cout, ovf);
    else passCnt++;
    void'(sbq.pop_front());
    @(posedge clk); #1;
    rstN = 1'b1;
    issue(64'd3, 64'd4, 1'b0, 1'b0);
    checkCnt++;
    if (busy !== 1'b1) $display("[TB] FAIL first_start got busy=%b, want 1", busy);
    else passCnt++;
    wait_done(lat, bc);
    e = sbq.pop_front();
    checkCnt++;
    if (done !== 1'b1 || result !== e.res) $display("[TB] FAIL after_reset_result got done=%b result=%h, want done=1 result=%h", done, result, e.res);
    else passCnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [DW-1:0] va[8];
    logic [DW-1:0] vb[8];
    logic          vc[8];
    logic          vs[8];
    exp_t e;
    int lat, bc;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = 64'd5;                   vb[1] = 64'd7; vc[1] = 1'b0; vs[1] = 1'b1;
    va[2] = 64'd7;                   vb[2] = 64'd5; vc[2] = 1'b1; vs[2] = 1'b1;
    va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vc[3] = 1'b0; vs[3] = 1'b0;
    va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vc[4] = 1'b0; vs[4] = 1'b1;
    va[5] = 64'h0123_4567_89AB_CDEF; vb[5] = 64'hFEDC_BA98_7654_3210; vc[5] = 1'b1; vs[5] = 1'b0;
    va[6] = {$urandom, $urandom};    vb[6] = {$urandom, $urandom}; vc[6] = 1'b1; vs[6] = 1'b0;
    va[7] = {$urandom, $urandom};    vb[7] = {$urandom, $urandom}; vc[7] = 1'b0; vs[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vc[i], vs[i]);
      wait_done(lat, bc);
      e = sbq.pop_front();
      checkCnt++;
      if (lat !== NCH || done !== 1'b1) $display("[TB] FAIL latency[%0d] got %0d edges done=%b, want %0d edges done=1", i, lat, done, NCH);
      else passCnt++;
      checkCnt++;
      if (bc !== NCH) $display("[TB] FAIL busy_cycles[%0d] got %0d, want %0d", i, bc, NCH);
      else passCnt++;
      checkCnt++;
      if (result !== e.res) $display("[TB] FAIL result[%0d] got %h, want %h", i, result, e.res);
      else passCnt++;
      checkCnt++;
      if (cout !== e.co || ovf !== e.ov) $display("[TB] FAIL flags[%0d] got cout=%b ovf=%b, want cout=%b ovf=%b", i, cout, ovf, e.co, e.ov);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e.res || cout !== e.co) $display("[TB] FAIL hold[%0d] got done=%b busy=%b result=%h cout=%b, want done=0 busy=0 result=%h cout=%b", i, done, busy, result, cout, e.res, e.co);
      else passCnt++;
    end
  endtask

  task automatic test_abuse();
    exp_t e;
    int lat, bc;
    logic seen;
    issue(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1234_5678_9ABC_DEF0; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    e = sbq.pop_front();
    checkCnt++;
    if (lat !== NCH - 3 || done !== 1'b1) $display("[TB] FAIL abuse_latency got %0d done=%b, want %0d done=1", lat, done, NCH - 3);
    else passCnt++;
    checkCnt++;
    if (result !== e.res || cout !== e.co || ovf !== e.ov) $display("[TB] FAIL abuse_result got %h/%b/%b, want %h/%b/%b", result, cout, ovf, e.res, e.co, e.ov);
    else passCnt++;
    @(posedge clk); #1;
    checkCnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL abuse_no_extra got busy=%b done=%b, want 0 0", busy, done);
    else passCnt++;
    issue(64'h5555_5555_5555_5555, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rstN = 1'b0;
    #2 rstN = 1'b1;
    void'(sbq.pop_back());
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    checkCnt++;
    if (seen !== 1'b0) $display("[TB] FAIL abort_no_done got activity=%b, want 0", seen);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, bc;
    issue(64'd10, 64'd20, 1'b0, 1'b0);
    wait_done(lat, bc);
    e = sbq.pop_front();
    checkCnt++;
    if (done !== 1'b1 || result !== e.res) $display("[TB] FAIL b2b_first got done=%b result=%h, want 1 %h", done, result, e.res);
    else passCnt++;
    issue(64'd3, 64'd4, 1'b0, 1'b0);
    checkCnt++;
    if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL b2b_no_bubble got busy=%b done=%b, want 1 0", busy, done);
    else passCnt++;
    wait_done(lat, bc);
    e = sbq.pop_front();
    checkCnt++;
    if (lat !== NCH || bc !== NCH || done !== 1'b1) $display("[TB] FAIL b2b_latency got lat=%0d busy=%0d done=%b, want %0d %0d 1", lat, bc, done, NCH, NCH);
    else passCnt++;
    checkCnt++;
    if (result !== e.res || result !== 64'd7) $display("[TB] FAIL b2b_result got %h, want %h", result, e.res);
    else passCnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_abuse();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
